// File: rtl/uart_pkg.sv
// Shared serial-debug-unit definitions: byte width, arbiter FSM states,
// default arbiter lock timeout.
package uart_pkg;

  localparam int BYTE_W          = 8;
  localparam int ARB_TIMEOUT_DEF = 1024;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping
// N-1 -> 0 explicitly so N need not be a power of two.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cand_i;
  logic             found;

  always_comb begin
    pick   = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    cand_i = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k + 1);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      cand_i = cand[IDX_W-1:0];
      if (!found && req[cand_i]) begin
        found        = 1'b1;
        pick[cand_i] = 1'b1;
        idx          = cand_i;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one uart_tx among N byte streams.
// Optional lock timeout is built when ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_vld,
  input  logic [BYTE_W*N-1:0]   req_data,
  input  logic [N-1:0]          req_last,
  output logic [N-1:0]          req_rdy,
  output logic [BYTE_W-1:0]     d_tx,
  output logic                  vld_tx,
  input  logic                  rdy_tx,
  output logic [N-1:0]          grant,
  output logic                  busy
);

  localparam int IDX_W = $clog2(N);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("uart_tx_arbiter: N out of range");
  end
  if (TIMEOUT < 2) begin : g_bad_to
    $error("uart_tx_arbiter: TIMEOUT too small");
  end

  arb_state_e       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] own_q, own_d;
  logic [N-1:0]     pick;
  logic [IDX_W-1:0] pick_idx;
  logic             own_vld;
  logic             own_last;
  logic             xfer;
  logic             to_hit;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req  (req_vld),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign busy     = (state_q == ARB_LOCK);
  assign grant    = grant_q;
  assign own_vld  = req_vld[own_q];
  assign own_last = req_last[own_q];
  assign xfer     = busy & own_vld & rdy_tx;
  assign vld_tx   = busy & own_vld;
  assign d_tx     = busy ? req_data[int'(own_q)*BYTE_W +: BYTE_W] : '0;
  assign req_rdy  = grant_q & {N{rdy_tx}};

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmr_q, tmr_d;

  // Counts cycles the owner leaves the TX starved inside a packet.
  always_comb begin
    tmr_d  = tmr_q;
    to_hit = 1'b0;
    if (!busy || xfer) begin
      tmr_d = '0;
    end else if (!own_vld) begin
      tmr_d = tmr_q + CNT_W'(1);
      if (tmr_d == CNT_W'(TIMEOUT)) begin
        to_hit = 1'b1;
        tmr_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req_vld) begin
          state_d = ARB_LOCK;
          grant_d = pick;
          own_d   = pick_idx;
        end
      end
      ARB_LOCK: begin
        if ((xfer && own_last) || to_hit) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = own_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(N - 1);
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: N=4, TIMEOUT=16; the timeout scenario
// follows ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_vld;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_rdy;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx;
  logic [3:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N(4), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_data (req_data),
    .req_last (req_last),
    .req_rdy  (req_rdy),
    .d_tx     (d_tx),
    .vld_tx   (vld_tx),
    .rdy_tx   (rdy_tx),
    .grant    (grant),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req_vld  = '0;
    req_data = '0;
    req_last = '0;
    rdy_tx   = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req_vld  = '0;
    req_data = '0;
    req_last = '0;
    rdy_tx   = 1'b0;
    #3;
    checks++;
    if ({grant, busy, vld_tx, d_tx, req_rdy} !== 18'h0) begin
      errors++;
      $display("FAIL reset: grant=%b busy=%b vld=%b d=%h rdy=%b required all 0",
               grant, busy, vld_tx, d_tx, req_rdy);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_packet();
    do_reset();
    req_vld = 4'b0001; req_data = 32'h11; rdy_tx = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || vld_tx !== 1'b0) begin
      errors++;
      $display("FAIL pkt_pre: grant=%b vld=%b required 0000 0", grant, vld_tx);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || vld_tx !== 1'b1 ||
        d_tx !== 8'h11 || req_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL pkt_b0: grant=%b busy=%b vld=%b d=%h rdy=%b required 0001 1 1 11 0001",
               grant, busy, vld_tx, d_tx, req_rdy);
    end
    tick();
    req_data = 32'h22;
    #1;
    checks++;
    if (d_tx !== 8'h22 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL pkt_b1: d=%h grant=%b required 22 0001", d_tx, grant);
    end
    tick();
    req_data = 32'h33; req_last = 4'b0001;
    #1;
    checks++;
    if (d_tx !== 8'h33 || vld_tx !== 1'b1) begin
      errors++;
      $display("FAIL pkt_b2: d=%h vld=%b required 33 1", d_tx, vld_tx);
    end
    tick();
    req_vld = '0; req_last = '0;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || vld_tx !== 1'b0 || d_tx !== 8'h00) begin
      errors++;
      $display("FAIL pkt_end: grant=%b busy=%b vld=%b d=%h required 0000 0 0 00",
               grant, busy, vld_tx, d_tx);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    req_vld = 4'b1111; req_last = 4'b1111;
    req_data = 32'h43424140; rdy_tx = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_d = 8'h40 + 8'(k % 4);
      tick();
      checks++;
      if (grant !== exp_g || d_tx !== exp_d) begin
        errors++;
        $display("FAIL rr_grant%0d: grant=%b d=%h required %b %h", k, grant, d_tx, exp_g, exp_d);
      end
      tick();
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: grant=%b busy=%b required 0000 0", k, grant, busy);
      end
    end
    req_vld = '0; req_last = '0;
  endtask

  task automatic test_locked();
    logic [3:0] exp_next;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      req_vld = 4'b0100; req_data = 32'h00C00000; rdy_tx = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b0100) begin
        errors++;
        $display("FAIL lock_start%0d: grant=%b required 0100", v, grant);
      end
      req_vld = 4'b0111;
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (grant !== 4'b0100 || req_rdy !== 4'b0100) begin
          errors++;
          $display("FAIL lock_hold%0d_%0d: grant=%b rdy=%b required 0100 0100",
                   v, c, grant, req_rdy);
        end
      end
      req_last = 4'b0100;
      req_vld  = (v == 1) ? 4'b1111 : 4'b0111;
      tick();
      req_last = '0;
      #1;
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL lock_rel%0d: grant=%b busy=%b required 0000 0", v, grant, busy);
      end
      exp_next = (v == 1) ? 4'b1000 : 4'b0001;
      tick();
      checks++;
      if (grant !== exp_next) begin
        errors++;
        $display("FAIL lock_next%0d: grant=%b required %b", v, grant, exp_next);
      end
      req_vld = '0;
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_vld = 4'b0001; req_data = 32'hA5; req_last = 4'b0001; rdy_tx = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (d_tx !== 8'hA5 || vld_tx !== 1'b1 || req_rdy !== 4'b0000) begin
        errors++;
        $display("FAIL stall%0d: d=%h vld=%b rdy=%b required a5 1 0000", i, d_tx, vld_tx, req_rdy);
      end
      tick();
    end
    rdy_tx = 1'b1;
    #1;
    checks++;
    if (req_rdy !== 4'b0001 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL stall_go: rdy=%b grant=%b required 0001 0001", req_rdy, grant);
    end
    tick();
    req_vld = '0; req_last = '0;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: grant=%b busy=%b required 0000 0", grant, busy);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    req_vld = 4'b0010; req_data = 32'h00007700; rdy_tx = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL rstm_lock: grant=%b required 0010", grant);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || vld_tx !== 1'b0 || busy !== 1'b0 || req_rdy !== 4'b0000) begin
      errors++;
      $display("FAIL rstm_async: grant=%b vld=%b busy=%b rdy=%b required 0000 0 0 0000",
               grant, vld_tx, busy, req_rdy);
    end
    #1;
    rst = 1'b0;
    req_vld = 4'b0011; req_data = 32'h00007788;
    tick();
    checks++;
    if (grant !== 4'b0001 || d_tx !== 8'h88) begin
      errors++;
      $display("FAIL rstm_first: grant=%b d=%h required 0001 88", grant, d_tx);
    end
    req_vld = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    req_vld = 4'b0001; req_data = 32'h5A; rdy_tx = 1'b1;
    tick();
    tick();
    req_vld = '0;
    #1;
    checks++;
    if (busy !== 1'b1 || vld_tx !== 1'b0) begin
      errors++;
      $display("FAIL to_drop: busy=%b vld=%b required 1 0", busy, vld_tx);
    end
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL to_hold%0d: busy=%b required 1", i, busy);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL to_release: busy=%b grant=%b required 0 0000", busy, grant);
    end
`else
    repeat (100) tick();
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL to_held: busy=%b grant=%b required 1 0001", busy, grant);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_packet();
    test_round_robin();
    test_locked();
    test_stall();
    test_rst_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
